dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the pipeline memory stage (initiator) and a slower backing memory (responder on the far side).
- Answers memory-stage loads and stores. Read hits complete in the same cycle.
- Raises stall_o to the hazard unit while a backing-memory transaction is outstanding.
- Drives a req/ack handshake towards backing memory.

Parameters:
- DATA_WIDTH, 32, word width of pipeline and backing memory.
- ADDR_WIDTH, 32, byte-address width.
- SETS, 16, number of lines; must be a power of 2 (one word per line).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- rd_en_i  in  1  load request from memory stage.
- wr_en_i  in  1  store request from memory stage.
- addr_i  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
- data_i  in  DATA_WIDTH  store data.
- data_o  out  DATA_WIDTH  load data.
- stall_o  out  1  freeze pipeline; request inputs held stable while high.
- mem_req_o  out  1  backing-memory request.
- mem_we_o  out  1  1 = write, 0 = read.
- mem_addr_o  out  ADDR_WIDTH  word-aligned address, bits [1:0] = 0.
- mem_wdata_o  out  DATA_WIDTH  write data.
- mem_rdata_i  in  DATA_WIDTH  read data, valid with mem_ack_i.
- mem_ack_i  in  1  one-cycle completion pulse.

Behaviour:
- Address split:
  - index = addr_i[2 +: log2(SETS)]
  - tag = remaining upper bits
  - hit = valid[index] && tag match
- Reset (async): all valid bits 0, state IDLE, mem_req_o/mem_we_o 0, mem_addr_o/mem_wdata_o 0, stall_o 0, data_o 0.
- States:
  - IDLE:
    - wr_en_i → latch address/data, go to WRITE, stall_o=1 this cycle.
    - else rd_en_i && !hit → latch address, go to FILL, stall_o=1.
    - else rd_en_i && hit → data_o = line data combinationally, stall_o=0, stay.
    - No request → stay.
  - FILL: mem_req_o=1, mem_we_o=0; stall_o = !mem_ack_i.
    - On mem_ack_i: write line data, tag and valid=1; data_o=mem_rdata_i that cycle; next state IDLE.
  - WRITE: mem_req_o=1, mem_we_o=1, mem_wdata_o = latched data; stall_o = !mem_ack_i.
    - On mem_ack_i: if latched address hits, update line data (tag/valid unchanged); on a miss, do not allocate. Next state IDLE.
- mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o are registered and stay stable until the ack cycle. They deassert on the edge after ack.
- Latency:
  - Read hit: 0 stall cycles.
  - Read miss or write: minimum 1 stall cycle (detect cycle), plus one cycle per cycle without ack in FILL/WRITE.
  - Ack on the first request cycle → total stall 1.
- rd_en_i && wr_en_i together: the write wins and the read is ignored.
- mem_ack_i in IDLE is ignored with no state change.
- data_o outside a hit or ack-cycle is don't-care; the implementation drives 0.
- Back-to-back requests: a new request may be accepted in the IDLE cycle immediately after an ack.
- Reset mid-transaction: abort, return to IDLE, and invalidate all lines. A late ack after reset is ignored.
- Store data is the full word; there are no byte enables.

Decomposition:
- Package dcache_pkg:
  - state enum (IDLE, FILL, WRITE)
  - localparams INDEX_W = $clog2(SETS), TAG_W = ADDR_WIDTH - INDEX_W - 2
  - helper functions get_index and get_tag
- Sub-module dcache_array:
  - valid/tag/data storage, combinational read port, one synchronous write port.
  - Takes a valid-clear input driven by reset.

Test Plan:
- Cold read addr 0x40, ack 2 cycles after req with rdata 0xDEADBEEF → stall_o high 3 cycles; data_o=0xDEADBEEF in ack cycle; mem_addr_o=0x40, mem_we_o=0.
- Repeat read 0x40 → stall_o=0, data_o=0xDEADBEEF same cycle, mem_req_o stays 0.
- Write 0x40 data 0x12345678 (hit), ack immediately → 1 stall cycle; mem_we_o=1, mem_wdata_o=0x12345678; subsequent read 0x40 hits with 0x12345678.
- Write 0x80 (miss, SETS=16) → write-through only; subsequent read 0x80 misses and issues mem_req_o.
- Conflict: read 0x40 then 0x440 (same index, different tag) → second misses and evicts; read 0x40 again misses.
- Assert rst_i during FILL before ack → mem_req_o drops asynchronously, stall_o=0; subsequent read 0x40 misses; stray mem_ack_i in IDLE causes no change.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and address helpers for the direct-mapped write-through data cache.
// Helpers take the index width as an argument so any SETS/ADDR_WIDTH geometry can reuse them.
package dcache_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2
   } state_e;

   localparam int unsigned ADDR_WIDTH_DEF = 32;
   localparam int unsigned SETS_DEF       = 16;
   localparam int unsigned INDEX_W        = $clog2(SETS_DEF);
   localparam int unsigned TAG_W          = ADDR_WIDTH_DEF - INDEX_W - 2;

   // Widest address the helpers accept; callers zero-extend and truncate the result.
   localparam int unsigned MAX_AW = 64;

   function automatic logic [MAX_AW-1:0] get_index(input logic [MAX_AW-1:0] addr,
                                                   input int unsigned       index_w);
      return (addr >> 2) & ((MAX_AW'(1) << index_w) - MAX_AW'(1));
   endfunction

   function automatic logic [MAX_AW-1:0] get_tag(input logic [MAX_AW-1:0] addr,
                                                 input int unsigned       index_w);
      return addr >> (index_w + 2);
   endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data line storage: combinational read, one synchronous write, async valid clear.
// Zero-latency read; the write port is always accepted, no backpressure.
module dcache_array #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned IDX_W      = 4,
   parameter int unsigned TG_W       = 26
) (
   input  logic                  clk_i,
   input  logic                  clr_i,
   input  logic [IDX_W-1:0]      rd_idx_i,
   output logic                  rd_vld_o,
   output logic [TG_W-1:0]       rd_tag_o,
   output logic [DATA_WIDTH-1:0] rd_dat_o,
   input  logic                  wr_en_i,
   input  logic [IDX_W-1:0]      wr_idx_i,
   input  logic [TG_W-1:0]       wr_tag_i,
   input  logic [DATA_WIDTH-1:0] wr_dat_i
);

   localparam int unsigned SETS = 1 << IDX_W;

   logic [SETS-1:0]       valid_q, valid_d;
   logic [TG_W-1:0]       tag_q  [SETS];
   logic [TG_W-1:0]       tag_d  [SETS];
   logic [DATA_WIDTH-1:0] data_q [SETS];
   logic [DATA_WIDTH-1:0] data_d [SETS];

   assign rd_vld_o = valid_q[rd_idx_i];
   assign rd_tag_o = tag_q[rd_idx_i];
   assign rd_dat_o = data_q[rd_idx_i];

   // Every write leaves the line valid: fills allocate, store hits rewrite the same tag.
   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      data_d  = data_q;
      if (wr_en_i) begin
         valid_d[wr_idx_i] = 1'b1;
         tag_d[wr_idx_i]   = wr_tag_i;
         data_d[wr_idx_i]  = wr_dat_i;
      end
   end

   always_ff @(posedge clk_i or posedge clr_i) begin
      if (clr_i) valid_q <= '0;
      else       valid_q <= valid_d;
   end

   always_ff @(posedge clk_i) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through no-write-allocate D-cache; read hits answer same cycle.
// Misses and stores stall for the detect cycle plus every FILL/WRITE cycle without mem_ack_i.
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned SETS       = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  rd_en_i,
   input  logic                  wr_en_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  stall_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   input  logic                  mem_ack_i
);

   localparam int unsigned IDX_W = $clog2(SETS);
   localparam int unsigned TG_W  = ADDR_WIDTH - IDX_W - 2;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  mem_req_q, mem_req_d;
   logic                  mem_we_q, mem_we_d;

   logic [ADDR_WIDTH-1:0] lookup_addr;
   logic [ADDR_WIDTH-1:0] addr_aligned;
   logic [IDX_W-1:0]      lk_idx;
   logic [TG_W-1:0]       lk_tag;
   logic                  arr_vld;
   logic [TG_W-1:0]       arr_tag;
   logic [DATA_WIDTH-1:0] arr_dat;
   logic                  hit;
   logic                  arr_wr_en;
   logic [DATA_WIDTH-1:0] arr_wr_dat;

   // While a transaction is open the array is probed with the latched address, so the
   // single index serves both the ack-cycle hit check and the line write.
   assign lookup_addr  = (state_q == IDLE) ? addr_i : addr_q;
   assign addr_aligned = {addr_i[ADDR_WIDTH-1:2], 2'b00};
   assign lk_idx       = IDX_W'(get_index(MAX_AW'(lookup_addr), IDX_W));
   assign lk_tag       = TG_W'(get_tag(MAX_AW'(lookup_addr), IDX_W));
   assign hit          = arr_vld && (arr_tag == lk_tag);

   dcache_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .IDX_W      (IDX_W),
      .TG_W       (TG_W)
   ) u_array (
      .clk_i    (clk_i),
      .clr_i    (rst_i),
      .rd_idx_i (lk_idx),
      .rd_vld_o (arr_vld),
      .rd_tag_o (arr_tag),
      .rd_dat_o (arr_dat),
      .wr_en_i  (arr_wr_en),
      .wr_idx_i (lk_idx),
      .wr_tag_i (lk_tag),
      .wr_dat_i (arr_wr_dat)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      mem_req_d  = mem_req_q;
      mem_we_d   = mem_we_q;
      stall_o    = 1'b0;
      data_o     = '0;
      arr_wr_en  = 1'b0;
      arr_wr_dat = mem_rdata_i;

      // Outputs stay quiet while reset is held even if the stage keeps its request up.
      if (!rst_i) begin
         unique case (state_q)
            IDLE: begin
               if (wr_en_i) begin
                  addr_d    = addr_aligned;
                  wdata_d   = data_i;
                  mem_req_d = 1'b1;
                  mem_we_d  = 1'b1;
                  state_d   = WRITE;
                  stall_o   = 1'b1;
               end else if (rd_en_i && !hit) begin
                  addr_d    = addr_aligned;
                  mem_req_d = 1'b1;
                  mem_we_d  = 1'b0;
                  state_d   = FILL;
                  stall_o   = 1'b1;
               end else if (rd_en_i) begin
                  data_o = arr_dat;
               end
            end
            FILL: begin
               stall_o = !mem_ack_i;
               if (mem_ack_i) begin
                  arr_wr_en = 1'b1;
                  data_o    = mem_rdata_i;
                  mem_req_d = 1'b0;
                  mem_we_d  = 1'b0;
                  state_d   = IDLE;
               end
            end
            WRITE: begin
               stall_o = !mem_ack_i;
               if (mem_ack_i) begin
                  arr_wr_en  = hit;
                  arr_wr_dat = wdata_q;
                  mem_req_d  = 1'b0;
                  mem_we_d   = 1'b0;
                  state_d    = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         mem_req_q <= 1'b0;
         mem_we_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         mem_req_q <= mem_req_d;
         mem_we_q  <= mem_we_d;
      end
   end

   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized bench for dcache_ctrl against a line-level cache model and a backing-memory map.
module tb_dcache_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        rd_en_i, wr_en_i;
   logic [31:0] addr_i, data_i, data_o;
   logic        stall_o, mem_req_o, mem_we_o;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
   logic        mem_ack_i;

   always #5 clk_i = ~clk_i;

   dcache_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SETS(16)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .rd_en_i     (rd_en_i),
      .wr_en_i     (wr_en_i),
      .addr_i      (addr_i),
      .data_i      (data_i),
      .data_o      (data_o),
      .stall_o     (stall_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata_i),
      .mem_ack_i   (mem_ack_i)
   );

   int n_chk  = 0;
   int n_fail = 0;

   bit          m_vld [16];
   logic [25:0] m_tag [16];
   logic [31:0] m_dat [16];
   logic [31:0] backing [logic [31:0]];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      if (backing.exists(a)) return backing[a];
      return a ^ 32'h5A5A_0F0F;
   endfunction

   // Entered and left at posedge+1; samples at posedge+5.
   task automatic do_op(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdat, input int delay, input string tag);
      logic [31:0] wa;
      int          idx;
      logic [25:0] tg;
      bit          exp_hit;
      int          stalls;
      wa      = {addr[31:2], 2'b00};
      idx     = int'((addr >> 2) & 32'hF);
      tg      = 26'(addr >> 6);
      exp_hit = rd && !wr && m_vld[idx] && (m_tag[idx] == tg);
      stalls  = 0;

      rd_en_i = rd;
      wr_en_i = wr;
      addr_i  = addr;
      data_i  = wdat;
      #4;
      if (exp_hit) begin
         check_eq({tag, "_hit_stall"}, 32'(stall_o), 32'd0);
         check_eq({tag, "_hit_data"}, data_o, m_dat[idx]);
         check_eq({tag, "_hit_req"}, 32'(mem_req_o), 32'd0);
         @(posedge clk_i); #1;
         rd_en_i = 1'b0;
         wr_en_i = 1'b0;
         return;
      end

      check_eq({tag, "_detect_stall"}, 32'(stall_o), 32'd1);
      if (stall_o) stalls++;
      @(posedge clk_i); #1;
      for (int k = 0; k <= delay; k++) begin
         mem_ack_i   = (k == delay);
         mem_rdata_i = (k == delay) ? mem_val(wa) : $urandom;
         #4;
         check_eq({tag, "_req"}, 32'(mem_req_o), 32'd1);
         check_eq({tag, "_we"}, 32'(mem_we_o), 32'(wr));
         check_eq({tag, "_addr"}, mem_addr_o, wa);
         if (wr) check_eq({tag, "_wdata"}, mem_wdata_o, wdat);
         check_eq({tag, "_xfer_stall"}, 32'(stall_o), 32'(k != delay));
         if (!wr && k == delay) check_eq({tag, "_fill_data"}, data_o, mem_val(wa));
         if (stall_o) stalls++;
         @(posedge clk_i); #1;
      end
      mem_ack_i = 1'b0;
      rd_en_i   = 1'b0;
      wr_en_i   = 1'b0;
      check_eq({tag, "_req_drop"}, 32'(mem_req_o), 32'd0);
      check_eq({tag, "_stall_total"}, 32'(stalls), 32'(1 + delay));

      if (wr) begin
         backing[wa] = wdat;
         if (m_vld[idx] && m_tag[idx] == tg) m_dat[idx] = wdat;
      end else begin
         m_vld[idx] = 1'b1;
         m_tag[idx] = tg;
         m_dat[idx] = mem_val(wa);
      end
   endtask

   initial begin
      logic [31:0] ra;
      logic [25:0] rt;
      bit          rrd, rwr;

      rst_i       = 1'b1;
      rd_en_i     = 1'b0;
      wr_en_i     = 1'b0;
      addr_i      = '0;
      data_i      = '0;
      mem_rdata_i = '0;
      mem_ack_i   = 1'b0;
      for (int i = 0; i < 16; i++) m_vld[i] = 1'b0;

      #12;
      check_eq("rst_stall", 32'(stall_o), 32'd0);
      check_eq("rst_req", 32'(mem_req_o), 32'd0);
      check_eq("rst_we", 32'(mem_we_o), 32'd0);
      check_eq("rst_addr", mem_addr_o, 32'd0);
      check_eq("rst_wdata", mem_wdata_o, 32'd0);
      check_eq("rst_data", data_o, 32'd0);
      #1 rst_i = 1'b0;
      @(posedge clk_i); #1;

      backing[32'h40] = 32'hDEADBEEF;
      do_op(1, 0, 32'h40, 32'h0, 2, "cold_rd");
      do_op(1, 0, 32'h40, 32'h0, 0, "rehit");
      do_op(0, 1, 32'h40, 32'h12345678, 0, "wr_hit");
      do_op(1, 0, 32'h40, 32'h0, 0, "rd_after_wr");
      do_op(0, 1, 32'h80, 32'hCAFEF00D, 1, "wr_miss");
      do_op(1, 0, 32'h80, 32'h0, 0, "rd_80");
      do_op(1, 0, 32'h440, 32'h0, 1, "conflict");
      do_op(1, 0, 32'h40, 32'h0, 0, "evicted");
      do_op(1, 1, 32'h47, 32'h0BADF00D, 1, "rd_wr_both");
      do_op(1, 0, 32'h46, 32'h0, 0, "low_bits");

      // Abort a fill with reset, then a stray ack must be ignored.
      rd_en_i = 1'b1;
      addr_i  = 32'h100;
      #4 check_eq("abort_detect", 32'(stall_o), 32'd1);
      @(posedge clk_i); #1;
      check_eq("abort_req_up", 32'(mem_req_o), 32'd1);
      #1 rst_i = 1'b1;
      #1;
      check_eq("abort_req", 32'(mem_req_o), 32'd0);
      check_eq("abort_stall", 32'(stall_o), 32'd0);
      rd_en_i = 1'b0;
      for (int i = 0; i < 16; i++) m_vld[i] = 1'b0;
      @(posedge clk_i); #2 rst_i = 1'b0;
      @(posedge clk_i); #1;
      mem_ack_i   = 1'b1;
      mem_rdata_i = 32'hFFFF_FFFF;
      #4;
      check_eq("stray_ack_stall", 32'(stall_o), 32'd0);
      @(posedge clk_i); #1;
      mem_ack_i = 1'b0;
      #4;
      check_eq("stray_ack_req", 32'(mem_req_o), 32'd0);
      check_eq("stray_ack_stall2", 32'(stall_o), 32'd0);
      @(posedge clk_i); #1;
      do_op(1, 0, 32'h40, 32'h0, 1, "post_rst");

      for (int n = 0; n < 300; n++) begin
         rt  = ($urandom_range(0, 7) == 0) ? 26'h3FFFFFF : 26'($urandom_range(0, 3));
         ra  = {rt, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
         rrd = ($urandom_range(0, 2) != 0);
         rwr = ($urandom_range(0, 3) == 0);
         if (!rrd && !rwr) rrd = 1'b1;
         do_op(rrd, rwr, ra, $urandom, $urandom_range(0, 3), "rand");
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk_i); #1;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
